// File: rtl/pifo_tb_phase_controller.sv
// Phase sequencer for PIFO bench runs: IDLE -> WARMUP -> GENERATE -> DRAIN -> DONE.
// Optional statistics outputs are enabled with the macro PIFO_TB_PHASE_STATS_EN.
module pifo_tb_phase_controller #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i__start,
    input  logic                 i__abort,
    input  logic [CNT_WIDTH-1:0] i__warmup_cycles,
    input  logic [CNT_WIDTH-1:0] i__generate_cycles,
    input  logic [CNT_WIDTH-1:0] i__drain_timeout,
    input  logic                 i__pifo_empty,
    input  logic                 i__pifo_ready,
    output logic [2:0]           o__state,
    output logic                 o__generate_phase,
    output logic [CNT_WIDTH-1:0] o__phase_count,
    output logic                 o__dequeue_enable,
    output logic                 o__done,
    output logic                 o__drain_timeout,
    output logic [CNT_WIDTH-1:0] o__run_count
`ifdef PIFO_TB_PHASE_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] o__stall_cycles,
    output logic [CNT_WIDTH-1:0] o__drain_cycles
`endif
);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StWarmup   = 3'd1,
        StGenerate = 3'd2,
        StDrain    = 3'd3,
        StDone     = 3'd4
    } state_e;

    state_e               r_state;
    state_e               w_state_d;
    logic [CNT_WIDTH-1:0] r_phase_count;
    logic [CNT_WIDTH-1:0] w_phase_count_d;
    logic [CNT_WIDTH-1:0] r_warmup;
    logic [CNT_WIDTH-1:0] r_generate;
    logic [CNT_WIDTH-1:0] r_timeout;
    logic                 r_drain_timeout;
    logic [CNT_WIDTH-1:0] r_run_count;
    logic                 w_start_ok;
    logic                 w_timeout_hit;
    logic                 w_active;

    // Abort wins over start, so a start coinciding with abort is not accepted.
    assign w_start_ok = i__start && !i__abort && (r_state == StIdle || r_state == StDone);
    assign w_active   = (r_state == StWarmup) || (r_state == StGenerate) || (r_state == StDrain);

    // Next-state decode and phase counter update.
    always_comb begin
        w_state_d     = r_state;
        w_timeout_hit = 1'b0;
        unique case (r_state)
            StIdle: w_state_d = StIdle;
            StWarmup: begin
                if (r_phase_count == r_warmup - CNT_WIDTH'(1)) begin
                    w_state_d = (r_generate != '0) ? StGenerate : StDrain;
                end
            end
            StGenerate: begin
                if (r_phase_count == r_generate - CNT_WIDTH'(1)) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                // Empty takes precedence over a coincident timeout.
                if (i__pifo_empty) begin
                    w_state_d = StDone;
                end else if (r_timeout != '0 && r_phase_count == r_timeout - CNT_WIDTH'(1)) begin
                    w_state_d     = StDone;
                    w_timeout_hit = 1'b1;
                end
            end
            StDone: w_state_d = StDone;
            default: w_state_d = StIdle;
        endcase
        if (w_start_ok) begin
            if (i__warmup_cycles != '0) begin
                w_state_d = StWarmup;
            end else if (i__generate_cycles != '0) begin
                w_state_d = StGenerate;
            end else begin
                w_state_d = StDrain;
            end
        end
        if (i__abort) begin
            w_state_d     = StIdle;
            w_timeout_hit = 1'b0;
        end
        // Counter restarts at 0 on every phase entry and saturates while staying.
        w_phase_count_d = '0;
        if (w_active && w_state_d == r_state) begin
            w_phase_count_d = (r_phase_count == '1) ? r_phase_count
                                                    : r_phase_count + CNT_WIDTH'(1);
        end
    end

    // State, counters, captured run configuration and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= StIdle;
            r_phase_count   <= '0;
            r_warmup        <= '0;
            r_generate      <= '0;
            r_timeout       <= '0;
            r_drain_timeout <= 1'b0;
            r_run_count     <= '0;
        end else begin
            r_state       <= w_state_d;
            r_phase_count <= w_phase_count_d;
            if (w_start_ok) begin
                r_warmup   <= i__warmup_cycles;
                r_generate <= i__generate_cycles;
                r_timeout  <= i__drain_timeout;
            end
            if (w_start_ok || i__abort) begin
                r_drain_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_drain_timeout <= 1'b1;
            end
            if (w_state_d == StDone && r_state != StDone) begin
                r_run_count <= r_run_count + CNT_WIDTH'(1);
            end
        end
    end

`ifdef PIFO_TB_PHASE_STATS_EN
    logic [CNT_WIDTH-1:0] r_stall_cycles;
    logic [CNT_WIDTH-1:0] r_drain_cycles;

    // Stall and drain-length statistics; abort leaves them intact.
    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_stall_cycles <= '0;
            r_drain_cycles <= '0;
        end else begin
            if (r_state == StGenerate && !i__pifo_ready && r_stall_cycles != '1) begin
                r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
            end
            if (r_state == StDrain && w_state_d != StDrain) begin
                r_drain_cycles <= (r_phase_count == '1) ? r_phase_count
                                                        : r_phase_count + CNT_WIDTH'(1);
            end
        end
    end

    assign o__stall_cycles = r_stall_cycles;
    assign o__drain_cycles = r_drain_cycles;
`else
    logic w_unused_ready;
    assign w_unused_ready = i__pifo_ready;
`endif

    assign o__state          = r_state;
    assign o__generate_phase = (r_state == StGenerate);
    assign o__phase_count    = r_phase_count;
    assign o__dequeue_enable = (r_state == StGenerate) || (r_state == StDrain);
    assign o__done           = (r_state == StDone);
    assign o__drain_timeout  = r_drain_timeout;
    assign o__run_count      = r_run_count;

endmodule

// File: tb/tb_pifo_tb_phase_controller.sv
// Directed bench for pifo_tb_phase_controller.
module tb_pifo_tb_phase_controller;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start, abort_r, empty, ready;
    logic [W-1:0] warmup, gen, tmo;
    logic [2:0]   state;
    logic         gen_phase, deq_en, done, drain_to;
    logic [W-1:0] phase_count, run_count;
`ifdef PIFO_TB_PHASE_STATS_EN
    logic [W-1:0] stall_cycles, drain_cycles;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pifo_tb_phase_controller #(.CNT_WIDTH(W)) dut (
        .clk                (clk),
        .reset              (reset),
        .i__start           (start),
        .i__abort           (abort_r),
        .i__warmup_cycles   (warmup),
        .i__generate_cycles (gen),
        .i__drain_timeout   (tmo),
        .i__pifo_empty      (empty),
        .i__pifo_ready      (ready),
        .o__state           (state),
        .o__generate_phase  (gen_phase),
        .o__phase_count     (phase_count),
        .o__dequeue_enable  (deq_en),
        .o__done            (done),
        .o__drain_timeout   (drain_to),
        .o__run_count       (run_count)
`ifdef PIFO_TB_PHASE_STATS_EN
        ,
        .o__stall_cycles    (stall_cycles),
        .o__drain_cycles    (drain_cycles)
`endif
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Checks state, phase_count, generate_phase, dequeue_enable, done together.
    task automatic chk_phase(input string tag, input logic [2:0] st, input logic [W-1:0] cnt);
        chk({tag, ".state"}, W'(state), W'(st));
        chk({tag, ".count"}, phase_count, cnt);
        chk({tag, ".gen"}, W'(gen_phase), W'(st == 3'd2));
        chk({tag, ".deq"}, W'(deq_en), W'(st == 3'd2 || st == 3'd3));
        chk({tag, ".done"}, W'(done), W'(st == 3'd4));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort_r = 1'b0; empty = 1'b0; ready = 1'b1;
        warmup = '0; gen = '0; tmo = '0;
        tick(2);
        reset = 1'b0;
        tick();
        chk_phase("reset", 3'd0, 0);
        chk("reset.drain_to", W'(drain_to), 0);
        chk("reset.runs", run_count, 0);

        // Run 1: warmup 3, generate 5, empty at drain entry.
        warmup = 3; gen = 5; tmo = 0; empty = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk_phase("r1.wu0", 3'd1, 0);
        tick(2);
        chk_phase("r1.wu2", 3'd1, 2);
        tick();
        chk_phase("r1.gen0", 3'd2, 0);
        tick(4);
        chk_phase("r1.gen4", 3'd2, 4);
        tick();
        chk_phase("r1.drain", 3'd3, 0);
        tick();
        chk_phase("r1.done", 3'd4, 0);
        chk("r1.runs", run_count, 1);
        chk("r1.drain_to", W'(drain_to), 0);

        // Run 2: straight to drain, timeout 4 with PIFO never empty.
        warmup = 0; gen = 0; tmo = 4; empty = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk_phase("r2.drain0", 3'd3, 0);
        tick(3);
        chk_phase("r2.drain3", 3'd3, 3);
        tick();
        chk_phase("r2.done", 3'd4, 0);
        chk("r2.drain_to", W'(drain_to), 1);
        chk("r2.runs", run_count, 2);

        // Run 3: empty coincides with the timeout cycle; empty wins.
        start = 1'b1;
        tick(); start = 1'b0;
        chk("r3.drain_to_cleared", W'(drain_to), 0);
        tick(3);
        chk_phase("r3.drain3", 3'd3, 3);
        empty = 1'b1;
        tick();
        empty = 1'b0;
        chk_phase("r3.done", 3'd4, 0);
        chk("r3.drain_to", W'(drain_to), 0);
        chk("r3.runs", run_count, 3);

        // Abort together with start at GENERATE count 2.
        warmup = 0; gen = 5; tmo = 0; start = 1'b1;
        tick(); start = 1'b0;
        tick(2);
        chk_phase("ab.gen2", 3'd2, 2);
        abort_r = 1'b1; start = 1'b1;
        tick();
        abort_r = 1'b0; start = 1'b0;
        chk_phase("ab.idle", 3'd0, 0);
        chk("ab.drain_to", W'(drain_to), 0);
        chk("ab.runs", run_count, 3);
        tick();
        chk_phase("ab.idle_hold", 3'd0, 0);

        // Fresh run after abort; config changes and start pulses mid-run are ignored.
        warmup = 2; gen = 5; tmo = 0; empty = 1'b1; start = 1'b1;
        tick(); start = 1'b0;
        chk_phase("cfg.wu0", 3'd1, 0);
        gen = 100; warmup = 7; start = 1'b1;
        tick(); start = 1'b0;
        chk_phase("cfg.wu1", 3'd1, 1);
        tick();
        chk_phase("cfg.gen0", 3'd2, 0);
        tick(4);
        chk_phase("cfg.gen4", 3'd2, 4);
        tick();
        chk_phase("cfg.drain", 3'd3, 0);
        tick();
        chk_phase("cfg.done", 3'd4, 0);
        chk("cfg.runs", run_count, 4);

`ifdef PIFO_TB_PHASE_STATS_EN
        // Stats: 2 stalled GENERATE cycles out of 6, then a 3-cycle timed-out drain.
        warmup = 0; gen = 6; tmo = 3; empty = 1'b0; start = 1'b1;
        tick(); start = 1'b0;
        chk("st.cleared_stall", stall_cycles, 0);
        chk("st.cleared_drain", drain_cycles, 0);
        ready = 1'b0;
        tick(2);
        ready = 1'b1;
        tick(4);
        chk_phase("st.drain0", 3'd3, 0);
        chk("st.stall", stall_cycles, 2);
        tick(3);
        chk_phase("st.done", 3'd4, 0);
        chk("st.drain_cycles", drain_cycles, 3);
        chk("st.drain_to", W'(drain_to), 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
